// File: rtl/log2_sched_pkg.sv
// Shared types and the round-robin pick function for the log2 scheduler.
package log2_sched_pkg;

  localparam int unsigned MAX_NREQ = 16;
  localparam int unsigned PTRW     = 4;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  // First valid requester at or after ptr, wrapping modulo nreq; returns ptr when none are valid.
  function automatic logic [PTRW-1:0] rr_pick(input logic [MAX_NREQ-1:0] valid,
                                              input logic [PTRW-1:0]     ptr,
                                              input int unsigned         nreq);
    logic        found;
    int unsigned j;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      j = (32'(ptr) + i) % nreq;
      if (!found && i < nreq && valid[j[PTRW-1:0]]) begin
        rr_pick = j[PTRW-1:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/log2_iter_engine.sv
// Floor-log2 engine: MSB-down bit scan, or a one-cycle priority encoder when
// LOG2_SCHED_FASTPATH_EN is defined. Operand must stay stable while busy.
module log2_iter_engine #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] operand,
  output logic         done,
  output logic [M-1:0] result,
  output logic         zero
);

  logic busy;

  assign zero = (operand == '0);

`ifdef LOG2_SCHED_FASTPATH_EN
  always_comb begin
    result = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (operand[i]) result = M'(i);
    end
  end

  assign done = busy;

  always_ff @(posedge clk) begin
    if (rst)        busy <= 1'b0;
    else if (start) busy <= 1'b1;
    else if (done)  busy <= 1'b0;
  end
`else
  logic [M-1:0] idx;

  // A zero operand runs down to index 0 and reports 0.
  assign done   = busy && (operand[idx] || idx == '0);
  assign result = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      idx  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      idx  <= M'(N - 1);
    end else if (busy) begin
      if (done) busy <= 1'b0;
      else      idx  <= idx - M'(1);
    end
  end
`endif

endmodule

// File: rtl/log2_sched.sv
// Round-robin scheduler sharing one floor-log2 engine among NREQ requesters.
// Optional LOG2_SCHED_FASTPATH_EN selects a single-cycle engine.
module log2_sched
  import log2_sched_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned N    = 8,
  parameter  int unsigned M    = 3,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_value,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [M-1:0]      rsp_result,
  output logic              rsp_exact,
  output logic              rsp_zero
);

  if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
    $error("log2_sched: NREQ must be in 2..16");
  end
  if (M != $clog2(N)) begin : g_bad_m
    $error("log2_sched: M must equal $clog2(N)");
  end

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [N-1:0]   op_q;
  logic [IDW-1:0] win;
  logic [N-1:0]   sel_op;
  logic           any_valid;
  logic           accept;
  logic           eng_done;
  logic [M-1:0]   eng_result;
  logic           eng_zero;

  // Combinational arbitration; grant only offered while idle and out of reset.
  always_comb begin
    win       = IDW'(rr_pick(MAX_NREQ'(req_valid), PTRW'(ptr), NREQ));
    any_valid = |req_valid;
    accept    = (state == IDLE) && any_valid && !rst;
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
    sel_op = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) sel_op = req_value[i*N +: N];
    end
  end

  log2_iter_engine #(.N(N), .M(M)) u_engine (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .operand (op_q),
    .done    (eng_done),
    .result  (eng_result),
    .zero    (eng_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      op_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_exact  <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= sel_op;
            rsp_id <= win;
            ptr    <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
            state  <= CALC;
          end
        end
        CALC: begin
          if (eng_done) begin
            rsp_result <= eng_result;
            rsp_zero   <= eng_zero;
            rsp_exact  <= !eng_zero && (op_q == (N'(1) << eng_result));
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log2_sched.sv
// Directed and random checks for log2_sched (NREQ=4, N=8, M=3).
module tb_log2_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_value;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [2:0]  rsp_result;
  logic        rsp_exact;
  logic        rsp_zero;

  int checks   = 0;
  int failures = 0;

  log2_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_value  (req_value),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_exact  (rsp_exact),
    .rsp_zero   (rsp_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_log2(input logic [7:0] v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int ref_lat(input logic [7:0] v);
`ifdef LOG2_SCHED_FASTPATH_EN
    return 2;
`else
    return 1 + 8 - ref_log2(v);
`endif
  endfunction

  // Issue one request from requester id, then check grant, latency, fields and hold stability.
  task automatic run_op(input int id, input logic [7:0] v, input int hold);
    int k;
    int lat;
    logic [7:0] vv;
    vv = v;
    req_value[id*8 +: 8] = vv;
    req_valid[id] = 1'b1;
    #1;
    for (k = 0; k < 50 && !req_ready[id]; k++) begin
      @(negedge clk);
      #1;
    end
    check("grant", 32'(req_ready), 32'(1 << id));
    @(negedge clk);
    req_valid[id] = 1'b0;
    check("ready_calc", 32'(req_ready), 0);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(ref_lat(vv)));
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      check("rsp_valid", 32'(rsp_valid), 1);
      check("rsp_id", 32'(rsp_id), 32'(id));
      check("rsp_result", 32'(rsp_result), 32'(ref_log2(vv)));
      check("rsp_exact", 32'(rsp_exact), 32'((vv != 0) && ((vv & (vv - 8'd1)) == 0)));
      check("rsp_zero", 32'(rsp_zero), 32'(vv == 0));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int exp_id  [5] = '{0, 1, 2, 3, 0};
    int exp_res [5] = '{2, 3, 7, 5, 2};
    int k;
    logic seen;
    req_value = '0;
    do_reset();
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_id", 32'(rsp_id), 0);
    check("rst_result", 32'(rsp_result), 0);
    check("rst_ready", 32'(req_ready), 0);

    // Single requester 2, operand with MSB set.
    run_op(2, 8'd146, 0);

    // Back-pressure: response held five cycles, then idle again.
    run_op(0, 8'd64, 5);
    req_valid = 4'b1000;
    #1;
    check("idle_after_rsp", 32'(req_ready), 32'h8);
    req_valid = '0;
    @(negedge clk);

    // All four contending: round-robin order from pointer 0.
    do_reset();
    req_value = {8'd50, 8'd128, 8'd9, 8'd4};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      for (k = 0; k < 40 && !rsp_valid; k++) @(negedge clk);
      check("rr_valid", 32'(rsp_valid), 1);
      check("rr_id", 32'(rsp_id), 32'(exp_id[r]));
      check("rr_result", 32'(rsp_result), 32'(exp_res[r]));
      if (r == 4) req_valid = '0;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    @(negedge clk);

    // Zero operand takes the full scan.
    run_op(1, 8'd0, 0);

    // Reset in the middle of a calculation drops the operation.
    do_reset();
    req_value[15:8] = 8'd1;
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("rst_no_rsp", 32'(seen), 0);
    req_valid = 4'b1111;
    #1;
    check("rst_ptr", 32'(req_ready), 32'h1);
    req_valid = '0;
    @(negedge clk);
    run_op(3, 8'd20, 0);

    // Random traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      run_op(int'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
